// File: rtl/fft_pkg.sv
// Shared types for the FFT result readout path: reader FSM states, skid FIFO entry and the
// RAM read latency the reader is built around.
package fft_pkg;

   localparam int unsigned READ_LATENCY = 1;
   // One slot per read still in flight in the RAM plus one for the beat being presented.
   localparam int unsigned SKID_DEPTH   = READ_LATENCY + 1;

   // Entry fields are sized for the widest supported frame; the reader zero/sign-extends into
   // them, so FFT_DW must stay <= ENTRY_DW and FFT_N <= ENTRY_IW.
   localparam int unsigned ENTRY_DW = 32;
   localparam int unsigned ENTRY_IW = 16;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StDrain,
      StFin,
      StWaitClr
   } rd_state_e;

   typedef struct packed {
      logic signed [ENTRY_DW-1:0] re;
      logic signed [ENTRY_DW-1:0] im;
      logic        [ENTRY_IW-1:0] index;
      logic                       last;
   } fft_entry_t;

endpackage

// File: rtl/fft_out_skid.sv
// Two-entry synchronous FIFO absorbing the RAM read latency in front of the output stream.
module fft_out_skid
   import fft_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  fft_entry_t push_data,
   input  logic       pop,
   output fft_entry_t head,
   output logic [1:0] occ
);

   fft_entry_t mem_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] occ_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_q + 2'(push) - 2'(pop);
      end
   end

   assign head = mem_q[rd_ptr_q];
   assign occ  = occ_q;

endmodule

// File: rtl/fft_result_reader.sv
// Reads a finished FFT frame out of the core's result RAM and presents the bins as a
// valid/ready stream, then releases the core with a one-cycle fin pulse.
module fft_result_reader
   import fft_pkg::*;
#(
   parameter int unsigned FFT_LENGTH = 1024,
   parameter int unsigned FFT_DW     = 16,
   parameter int unsigned OUT_BINS   = FFT_LENGTH / 2,
   // Derived; not meant to be overridden.
   parameter int unsigned FFT_N      = $clog2(FFT_LENGTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     done,
   input  logic signed [7:0]        bfpexp,
   output logic                     fin,
   output logic                     dmaact,
   output logic        [FFT_N-1:0]  dmaa,
   input  logic signed [FFT_DW-1:0] dmadr_real,
   input  logic signed [FFT_DW-1:0] dmadr_imag,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [FFT_DW-1:0] m_real,
   output logic signed [FFT_DW-1:0] m_imag,
   output logic        [FFT_N-1:0]  m_index,
   output logic                     m_last,
   output logic signed [7:0]        m_bfpexp,
   output logic                     busy
);

   localparam logic [FFT_N-1:0] LAST_IDX = FFT_N'(OUT_BINS - 1);

   rd_state_e        state_q;
   logic [FFT_N-1:0] cnt_q;
   logic [FFT_N-1:0] addr_q;
   logic             inflight_q;
   logic [1:0]       occ;
   logic             pop;
   logic             issue;
   fft_entry_t       push_data;
   fft_entry_t       head;
   logic             unused_head;

   assign m_valid = (occ != 2'd0);
   assign pop     = m_valid & m_ready;

   // Only issue a read if its data is guaranteed a FIFO slot when it returns.
   assign issue = (state_q == StRead) &&
                  ((32'(occ) + 32'(inflight_q)) < (SKID_DEPTH + 32'(pop)));

   assign dmaact = issue;
   assign dmaa   = cnt_q;
   assign busy   = (state_q != StIdle);
   assign fin    = (state_q == StFin);

   always_comb begin
      push_data       = '0;
      push_data.re    = ENTRY_DW'(dmadr_real);
      push_data.im    = ENTRY_DW'(dmadr_imag);
      push_data.index = ENTRY_IW'(addr_q);
      push_data.last  = (addr_q == LAST_IDX);
   end

   fft_out_skid u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .occ       (occ)
   );

   assign m_real      = head.re[FFT_DW-1:0];
   assign m_imag      = head.im[FFT_DW-1:0];
   assign m_index     = head.index[FFT_N-1:0];
   assign m_last      = m_valid & head.last;
   assign unused_head = ^{head.re, head.im, head.index};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         m_bfpexp   <= '0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            addr_q <= cnt_q;
         end
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (done && en) begin
                  m_bfpexp <= bfpexp;
                  state_q  <= StRead;
               end
            end
            StRead: begin
               // Counter parks on the last bin so it is never seen beyond OUT_BINS-1.
               if (issue) begin
                  if (cnt_q == LAST_IDX) begin
                     state_q <= StDrain;
                  end else begin
                     cnt_q <= cnt_q + FFT_N'(1);
                  end
               end
            end
            StDrain: begin
               if (pop && m_last) begin
                  state_q <= StFin;
               end
            end
            StFin: begin
               state_q <= StWaitClr;
            end
            StWaitClr: begin
               if (!done) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
